// File: rtl/branch_pc_gen.sv
// branch_pc_gen: next-fetch-PC generator for the dual-issue front end.
// Ports: clk, resetn (async low), stall, flush/flush_pc, redirect/redirect_pc,
//   pta0/pta1 {dir,target} predictions, pc/pc_p4 registered group addresses,
//   inst_valid0/1 slot issue flags. Macro PCGEN_PERF_CNT_EN adds
//   pred_taken_cnt and redirect_cnt saturating counters.
module branch_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [32:0] pta0,
  input  logic [32:0] pta1,
  output logic [31:0] pc,
  output logic [31:0] pc_p4,
  output logic        inst_valid0,
  output logic        inst_valid1
`ifdef PCGEN_PERF_CNT_EN
  ,
  output logic [31:0] pred_taken_cnt,
  output logic [31:0] redirect_cnt
`endif
);

  typedef enum logic {SEQ, DS_PEND} state_t;

  state_t      state;
  state_t      nxt_state;
  logic [31:0] ds_target;
  logic [31:0] nxt_ds;
  logic [31:0] nxt_pc;
  logic [1:0]  nxt_v;
  logic        started;
  logic        nxt_started;
  logic        pt_hit;
  logic        rd_hit;

  always_comb begin
    nxt_pc      = pc;
    nxt_v       = {inst_valid0, inst_valid1};
    nxt_state   = state;
    nxt_ds      = ds_target;
    nxt_started = started;
    pt_hit      = 1'b0;
    rd_hit      = 1'b0;
    if (flush) begin
      nxt_pc      = flush_pc;
      nxt_v       = 2'b11;
      nxt_state   = SEQ;
      nxt_started = 1'b1;
      rd_hit      = 1'b1;
    end else if (redirect) begin
      nxt_pc      = redirect_pc;
      nxt_v       = 2'b11;
      nxt_state   = SEQ;
      nxt_started = 1'b1;
      rd_hit      = 1'b1;
    end else if (stall) begin
      nxt_pc = pc;
    end else if (!started) begin
      // reset group is issued in place on the first edge
      nxt_v       = 2'b11;
      nxt_started = 1'b1;
    end else if (state == DS_PEND) begin
      nxt_pc    = ds_target;
      nxt_v     = 2'b11;
      nxt_state = SEQ;
    end else if (pta0[32]) begin
      // slot1 is the delay slot and is already in this group
      nxt_pc = pta0[31:0];
      nxt_v  = 2'b11;
      pt_hit = 1'b1;
    end else if (pta1[32]) begin
      // next group carries only the delay slot, then jump
      nxt_pc    = pc + 32'd8;
      nxt_v     = 2'b10;
      nxt_ds    = pta1[31:0];
      nxt_state = DS_PEND;
      pt_hit    = 1'b1;
    end else begin
      nxt_pc = pc + 32'd8;
      nxt_v  = 2'b11;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc          <= RESET_PC;
      pc_p4       <= RESET_PC + 32'd4;
      inst_valid0 <= 1'b0;
      inst_valid1 <= 1'b0;
      state       <= SEQ;
      ds_target   <= 32'd0;
      started     <= 1'b0;
    end else begin
      pc          <= nxt_pc;
      pc_p4       <= nxt_pc + 32'd4;
      inst_valid0 <= nxt_v[1];
      inst_valid1 <= nxt_v[0];
      state       <= nxt_state;
      ds_target   <= nxt_ds;
      started     <= nxt_started;
    end
  end

`ifdef PCGEN_PERF_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pred_taken_cnt <= 32'd0;
      redirect_cnt   <= 32'd0;
    end else begin
      if (pt_hit && pred_taken_cnt != 32'hFFFF_FFFF)
        pred_taken_cnt <= pred_taken_cnt + 32'd1;
      if (rd_hit && redirect_cnt != 32'hFFFF_FFFF)
        redirect_cnt <= redirect_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_pc_gen.sv
// tb_branch_pc_gen: scoreboard bench for branch_pc_gen.
// Stimulus pushes expected group state; a monitor pops and compares.
module tb_branch_pc_gen;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [32:0] pta0 = '0;
  logic [32:0] pta1 = '0;
  logic [31:0] pc;
  logic [31:0] pc_p4;
  logic        inst_valid0;
  logic        inst_valid1;
`ifdef PCGEN_PERF_CNT_EN
  logic [31:0] pred_taken_cnt;
  logic [31:0] redirect_cnt;
`endif

  branch_pc_gen dut (
    .clk(clk),
    .resetn(resetn),
    .stall(stall),
    .flush(flush),
    .flush_pc(flush_pc),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .pta0(pta0),
    .pta1(pta1),
    .pc(pc),
    .pc_p4(pc_p4),
    .inst_valid0(inst_valid0),
    .inst_valid1(inst_valid1)
`ifdef PCGEN_PERF_CNT_EN
    ,
    .pred_taken_cnt(pred_taken_cnt),
    .redirect_cnt(redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] p4;
    logic [1:0]  v;
    logic [31:0] ptc;
    logic [31:0] rdc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_ptc = 0;
  int   m_rdc = 0;

  task automatic chk32(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk32({e.name, ".pc"}, pc, e.pc);
        chk32({e.name, ".pc_p4"}, pc_p4, e.p4);
        chk32({e.name, ".valid"},
              {30'd0, inst_valid0, inst_valid1}, {30'd0, e.v});
`ifdef PCGEN_PERF_CNT_EN
        chk32({e.name, ".pt_cnt"}, pred_taken_cnt, e.ptc);
        chk32({e.name, ".rd_cnt"}, redirect_cnt, e.rdc);
`endif
      end
    end
  end

  task automatic push(string nm, logic [31:0] epc, logic [1:0] ev);
    exp_t e;
    e.name = nm;
    e.pc   = epc;
    e.p4   = epc + 32'd4;
    e.v    = ev;
    e.ptc  = m_ptc;
    e.rdc  = m_rdc;
    q.push_back(e);
  endtask

  task automatic step(string nm, logic f, logic [31:0] fpc,
                      logic r, logic [31:0] rpc, logic st,
                      logic [32:0] p0, logic [32:0] p1,
                      logic [31:0] epc, logic [1:0] ev, logic pt);
    @(negedge clk);
    resetn      = 1'b1;
    flush       = f;
    flush_pc    = fpc;
    redirect    = r;
    redirect_pc = rpc;
    stall       = st;
    pta0        = p0;
    pta1        = p1;
    if (f || r) m_rdc++;
    if (pt) m_ptc++;
    push(nm, epc, ev);
  endtask

  task automatic go(string nm, logic [31:0] epc, logic [1:0] ev);
    step(nm, 0, 0, 0, 0, 0, '0, '0, epc, ev, 0);
  endtask

  task automatic redir(string nm, logic [31:0] rpc);
    step(nm, 0, 0, 1, rpc, 0, '0, '0, rpc, 2'b11, 0);
  endtask

  initial begin
    @(negedge clk);
    resetn = 1'b0;
    push("t1_rst", 32'hBFC0_0000, 2'b00);
    go("t1_first", 32'hBFC0_0000, 2'b11);
    go("t1_seq", 32'hBFC0_0008, 2'b11);
    // T2 slot0 taken
    redir("t2_rd", 32'h0000_1000);
    step("t2_tk", 0, 0, 0, 0, 0, {1'b1, 32'h2000}, {1'b1, 32'h5000},
         32'h0000_2000, 2'b11, 1);
    // T3 slot1 taken, delay-slot group ignores pta0
    redir("t3_rd", 32'h0000_1000);
    step("t3_ds", 0, 0, 0, 0, 0, '0, {1'b1, 32'h3000},
         32'h0000_1008, 2'b10, 1);
    step("t3_tg", 0, 0, 0, 0, 0, {1'b1, 32'h7000}, '0,
         32'h0000_3000, 2'b11, 0);
    // T4 stall while DS_PEND
    redir("t4_rd", 32'h0000_1000);
    step("t4_ds", 0, 0, 0, 0, 0, '0, {1'b1, 32'h3000},
         32'h0000_1008, 2'b10, 1);
    for (int i = 0; i < 3; i++)
      step("t4_st", 0, 0, 0, 0, 1, {1'b1, 32'h9000}, '0,
           32'h0000_1008, 2'b10, 0);
    go("t4_rel", 32'h0000_3000, 2'b11);
    // T5 redirect under stall in DS_PEND drops ds_target
    redir("t5_rd", 32'h0000_1000);
    step("t5_ds", 0, 0, 0, 0, 0, '0, {1'b1, 32'h3000},
         32'h0000_1008, 2'b10, 1);
    step("t5_rs", 0, 0, 1, 32'h4000, 1, '0, '0,
         32'h0000_4000, 2'b11, 0);
    go("t5_seq", 32'h0000_4008, 2'b11);
    // T6 flush beats redirect
    step("t6_fr", 1, 32'hBFC0_0380, 1, 32'h4000, 0, '0, '0,
         32'hBFC0_0380, 2'b11, 0);
    go("t6_seq", 32'hBFC0_0388, 2'b11);
    // flush under stall in DS_PEND
    step("t7_ds", 0, 0, 0, 0, 0, '0, {1'b1, 32'h6000},
         32'hBFC0_0390, 2'b10, 1);
    step("t7_fs", 1, 32'h0000_0200, 0, 0, 1, '0, '0,
         32'h0000_0200, 2'b11, 0);
    go("t7_seq", 32'h0000_0208, 2'b11);
    // address wrap and low-bit passthrough
    redir("t8_rd", 32'hFFFF_FFF8);
    go("t8_wrap", 32'h0000_0000, 2'b11);
    redir("t9_rd", 32'h0000_0102);
    go("t9_lsb", 32'h0000_010A, 2'b11);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
